// File: rtl/addr_slot_ctrl.sv
// addr_slot_ctrl: owns the address table that feeds the registered address comparator.
// An allocate runs IDLE -> LOOK -> EVAL. It either bumps the refcount of the matching slot
// or claims the lowest free slot. A release runs IDLE -> REL. It decrements the refcount and
// frees the slot when the count reaches zero.
// Optional feature: define ADDR_SLOT_FLUSH_EN to add a flush input. Flush clears every slot in
// one IDLE cycle.
// The comparator's active-low reset is driven with ~reset.
module addr_slot_ctrl #(
   parameter int unsigned NUM_SLOTS = 14,
   parameter int unsigned ADDR_W    = 19,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                        clk,
   input  logic                        reset,
`ifdef ADDR_SLOT_FLUSH_EN
   input  logic                        flush,
`endif
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_release,
   input  logic [ADDR_W-1:0]           req_addr,
   input  logic [3:0]                  req_slot,
   output logic [ADDR_W-1:0]           cmp_addr,
   input  logic [3:0]                  cmp_result,
   input  logic                        cmp_valid,
   output logic [NUM_SLOTS*ADDR_W-1:0] slot_addr,
   output logic [NUM_SLOTS-1:0]        slot_ena,
   output logic                        resp_valid,
   output logic [3:0]                  resp_slot,
   output logic                        resp_hit,
   output logic                        resp_full,
   output logic                        resp_err,
   output logic [3:0]                  free_count
);

   typedef enum logic [1:0] {StIdle, StLook, StEval, StRel} state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    cmp_addr_q, cmp_addr_d;
   logic [3:0]           rel_slot_q, rel_slot_d;
   logic [ADDR_W-1:0]    slot_addr_q [NUM_SLOTS];
   logic [ADDR_W-1:0]    slot_addr_d [NUM_SLOTS];
   logic [CNT_W-1:0]     cnt_q [NUM_SLOTS];
   logic [CNT_W-1:0]     cnt_d [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] ena_q, ena_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [3:0]           resp_slot_q, resp_slot_d;
   logic                 resp_hit_q, resp_hit_d;
   logic                 resp_full_q, resp_full_d;
   logic                 resp_err_q, resp_err_d;

   logic                 flush_req;
   logic                 free_found;
   logic [3:0]           free_idx;
   logic                 hit_ok;
   logic                 rel_ok;
   logic [3:0]           used;

`ifdef ADDR_SLOT_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   // Lowest-index free slot. The scan runs downward, so the last hit is the lowest index.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!ena_q[i]) begin
            free_found = 1'b1;
            free_idx   = 4'(i);
         end
      end
   end

   // Range and enable qualification for comparator hits and release targets.
   always_comb begin
      hit_ok = cmp_valid && (cmp_result != 4'd0) && (cmp_result <= 4'(NUM_SLOTS));
      rel_ok = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (rel_slot_q == 4'(i + 1) && ena_q[i]) rel_ok = 1'b1;
      end
   end

   // Free-slot count from the enable register.
   always_comb begin
      used = '0;
      for (int i = 0; i < NUM_SLOTS; i++) used = used + 4'(ena_q[i]);
      free_count = 4'(NUM_SLOTS) - used;
   end

   // Next-state, table update and response decode.
   always_comb begin
      state_d      = state_q;
      cmp_addr_d   = cmp_addr_q;
      rel_slot_d   = rel_slot_q;
      slot_addr_d  = slot_addr_q;
      cnt_d        = cnt_q;
      ena_d        = ena_q;
      resp_valid_d = 1'b0;
      resp_slot_d  = '0;
      resp_hit_d   = 1'b0;
      resp_full_d  = 1'b0;
      resp_err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (flush_req) begin
               ena_d = '0;
               for (int i = 0; i < NUM_SLOTS; i++) cnt_d[i] = '0;
            end else if (req_valid) begin
               if (req_release) begin
                  rel_slot_d = req_slot;
                  state_d    = StRel;
               end else begin
                  cmp_addr_d = req_addr;
                  state_d    = StLook;
               end
            end
         end
         StLook: state_d = StEval;
         StEval: begin
            state_d      = StIdle;
            resp_valid_d = 1'b1;
            if (hit_ok) begin
               resp_hit_d  = 1'b1;
               resp_slot_d = cmp_result;
               for (int i = 0; i < NUM_SLOTS; i++) begin
                  if (cmp_result == 4'(i + 1) && cnt_q[i] != '1) begin
                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  end
               end
            end else if (free_found) begin
               resp_slot_d = free_idx + 4'd1;
               for (int i = 0; i < NUM_SLOTS; i++) begin
                  if (free_idx == 4'(i)) begin
                     slot_addr_d[i] = cmp_addr_q;
                     ena_d[i]       = 1'b1;
                     cnt_d[i]       = CNT_W'(1);
                  end
               end
            end else begin
               resp_full_d = 1'b1;
            end
         end
         StRel: begin
            state_d      = StIdle;
            resp_valid_d = 1'b1;
            if (rel_ok) begin
               resp_slot_d = rel_slot_q;
               for (int i = 0; i < NUM_SLOTS; i++) begin
                  if (rel_slot_q == 4'(i + 1)) begin
                     cnt_d[i] = cnt_q[i] - CNT_W'(1);
                     // The address is kept after release. Only the enable drops.
                     if (cnt_q[i] <= CNT_W'(1)) ena_d[i] = 1'b0;
                  end
               end
            end else begin
               resp_err_d = 1'b1;
            end
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Table, request latch and response registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmp_addr_q   <= '0;
         rel_slot_q   <= '0;
         ena_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_slot_q  <= '0;
         resp_hit_q   <= 1'b0;
         resp_full_q  <= 1'b0;
         resp_err_q   <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_addr_q[i] <= '0;
            cnt_q[i]       <= '0;
         end
      end else begin
         cmp_addr_q   <= cmp_addr_d;
         rel_slot_q   <= rel_slot_d;
         ena_q        <= ena_d;
         resp_valid_q <= resp_valid_d;
         resp_slot_q  <= resp_slot_d;
         resp_hit_q   <= resp_hit_d;
         resp_full_q  <= resp_full_d;
         resp_err_q   <= resp_err_d;
         slot_addr_q  <= slot_addr_d;
         cnt_q        <= cnt_d;
      end
   end

   // Flatten the table for the comparator.
   always_comb begin
      slot_addr = '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_addr[i*ADDR_W +: ADDR_W] = slot_addr_q[i];
   end

   assign req_ready  = (state_q == StIdle) && !flush_req;
   assign cmp_addr   = cmp_addr_q;
   assign slot_ena   = ena_q;
   assign resp_valid = resp_valid_q;
   assign resp_slot  = resp_slot_q;
   assign resp_hit   = resp_hit_q;
   assign resp_full  = resp_full_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_addr_slot_ctrl.sv
// tb_addr_slot_ctrl: directed and random requests for addr_slot_ctrl.
// The bench contains a behavioural comparator and a table model.
module tb_addr_slot_ctrl;

   localparam int unsigned NUM_SLOTS = 14;
   localparam int unsigned ADDR_W    = 19;
   localparam int unsigned CNT_MAX   = 255;

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        flush;
   logic                        req_valid;
   logic                        req_ready;
   logic                        req_release;
   logic [ADDR_W-1:0]           req_addr;
   logic [3:0]                  req_slot;
   logic [ADDR_W-1:0]           cmp_addr;
   logic [3:0]                  cmp_result;
   logic                        cmp_valid;
   logic [NUM_SLOTS*ADDR_W-1:0] slot_addr;
   logic [NUM_SLOTS-1:0]        slot_ena;
   logic                        resp_valid;
   logic [3:0]                  resp_slot;
   logic                        resp_hit;
   logic                        resp_full;
   logic                        resp_err;
   logic [3:0]                  free_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   addr_slot_ctrl dut (
      .clk         (clk),
      .reset       (reset),
`ifdef ADDR_SLOT_FLUSH_EN
      .flush       (flush),
`endif
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_release (req_release),
      .req_addr    (req_addr),
      .req_slot    (req_slot),
      .cmp_addr    (cmp_addr),
      .cmp_result  (cmp_result),
      .cmp_valid   (cmp_valid),
      .slot_addr   (slot_addr),
      .slot_ena    (slot_ena),
      .resp_valid  (resp_valid),
      .resp_slot   (resp_slot),
      .resp_hit    (resp_hit),
      .resp_full   (resp_full),
      .resp_err    (resp_err),
      .free_count  (free_count)
   );

   // Comparator: registered single-match search. Its reset is active low.
   logic       cmp_rst_n;
   int         nmatch;
   logic [3:0] midx;
   assign cmp_rst_n = ~reset;

   always_comb begin
      nmatch = 0;
      midx   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (slot_ena[i] && slot_addr[i*ADDR_W +: ADDR_W] == cmp_addr) begin
            nmatch = nmatch + 1;
            midx   = 4'(i + 1);
         end
      end
   end

   always @(posedge clk or negedge cmp_rst_n) begin
      if (!cmp_rst_n) begin
         cmp_valid  <= 1'b0;
         cmp_result <= '0;
      end else begin
         cmp_valid  <= (nmatch == 1);
         cmp_result <= (nmatch == 1) ? midx : 4'd0;
      end
   end

   // Table model.
   logic [ADDR_W-1:0] m_addr [NUM_SLOTS];
   bit                m_ena  [NUM_SLOTS];
   int                m_cnt  [NUM_SLOTS];

   task automatic model_reset();
      for (int i = 0; i < NUM_SLOTS; i++) begin
         m_addr[i] = '0;
         m_ena[i]  = 1'b0;
         m_cnt[i]  = 0;
      end
   endtask

   function automatic logic [NUM_SLOTS-1:0] m_ena_vec();
      logic [NUM_SLOTS-1:0] v = '0;
      for (int i = 0; i < NUM_SLOTS; i++) v[i] = m_ena[i];
      return v;
   endfunction

   function automatic logic [NUM_SLOTS*ADDR_W-1:0] m_addr_vec();
      logic [NUM_SLOTS*ADDR_W-1:0] v = '0;
      for (int i = 0; i < NUM_SLOTS; i++) v[i*ADDR_W +: ADDR_W] = m_addr[i];
      return v;
   endfunction

   function automatic int m_free();
      int n = NUM_SLOTS;
      for (int i = 0; i < NUM_SLOTS; i++) if (m_ena[i]) n--;
      return n;
   endfunction

   task automatic check(input string tag, input logic [271:0] obs, input logic [271:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_table(input string tag);
      check({tag, " slot_ena"}, 272'(slot_ena), 272'(m_ena_vec()));
      check({tag, " free_count"}, 272'(free_count), 272'(m_free()));
      check({tag, " slot_addr"}, 272'(slot_addr), 272'(m_addr_vec()));
   endtask

   // Issue one request and check its response against the model.
   task automatic do_req(input string tag, input bit rel, input logic [ADDR_W-1:0] addr,
                         input logic [3:0] slot);
      int  exp_slot = 0;
      bit  exp_hit  = 0;
      bit  exp_full = 0;
      bit  exp_err  = 0;
      int  exp_lat;
      int  lat;
      int  found = -1;
      if (!rel) begin
         exp_lat = 3;
         for (int i = 0; i < NUM_SLOTS; i++) if (m_ena[i] && m_addr[i] == addr) found = i;
         if (found >= 0) begin
            exp_hit       = 1;
            exp_slot      = found + 1;
            m_cnt[found]  = (m_cnt[found] < CNT_MAX) ? m_cnt[found] + 1 : m_cnt[found];
         end else begin
            for (int i = NUM_SLOTS - 1; i >= 0; i--) if (!m_ena[i]) found = i;
            if (found >= 0) begin
               exp_slot      = found + 1;
               m_addr[found] = addr;
               m_ena[found]  = 1'b1;
               m_cnt[found]  = 1;
            end else begin
               exp_full = 1;
            end
         end
      end else begin
         exp_lat = 2;
         if (slot >= 1 && slot <= NUM_SLOTS && m_ena[slot-1]) begin
            exp_slot       = int'(slot);
            m_cnt[slot-1]  = m_cnt[slot-1] - 1;
            if (m_cnt[slot-1] == 0) m_ena[slot-1] = 1'b0;
         end else begin
            exp_err = 1;
         end
      end
      @(negedge clk);
      check({tag, " req_ready"}, 272'(req_ready), 272'(1));
      req_valid   = 1'b1;
      req_release = rel;
      req_addr    = addr;
      req_slot    = slot;
      @(negedge clk);
      // Scramble the request inputs so that the DUT must rely on its latched copy.
      req_valid = 1'b0;
      req_addr  = ADDR_W'($urandom);
      req_slot  = 4'($urandom);
      lat = 1;
      while (!resp_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 272'(lat), 272'(exp_lat));
      check({tag, " resp_valid"}, 272'(resp_valid), 272'(1));
      check({tag, " resp_slot"}, 272'(resp_slot), 272'(exp_slot));
      check({tag, " resp_hit"}, 272'(resp_hit), 272'(exp_hit));
      check({tag, " resp_full"}, 272'(resp_full), 272'(exp_full));
      check({tag, " resp_err"}, 272'(resp_err), 272'(exp_err));
      check_table(tag);
      @(negedge clk);
      check({tag, " pulse"}, 272'({resp_valid, resp_slot, resp_hit, resp_full, resp_err}),
            272'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      flush       = 1'b0;
      req_valid   = 1'b0;
      req_release = 1'b0;
      req_addr    = '0;
      req_slot    = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state.
      check("rst resp_valid", 272'(resp_valid), 272'(0));
      check("rst req_ready", 272'(req_ready), 272'(1));
      check("rst cmp_addr", 272'(cmp_addr), 272'(0));
      check_table("rst");

      // Tests 1 and 2: first claim, then a hit on the same address.
      do_req("t1 alloc", 1'b0, 19'h12345, 4'd0);
      check("t1 ena const", 272'(slot_ena), 272'(14'h0001));
      check("t1 free const", 272'(free_count), 272'(13));
      do_req("t2 hit", 1'b0, 19'h12345, 4'd0);

      // Test 3: fill the table, overflow it, free slot 5 and reclaim it.
      for (int i = 2; i <= 14; i++) do_req("t3 fill", 1'b0, 19'(32'h20000 + i), 4'd0);
      check("t3 full ena", 272'(slot_ena), 272'(14'h3fff));
      do_req("t3 overflow", 1'b0, 19'h30000, 4'd0);
      do_req("t3 rel5", 1'b1, '0, 4'd5);
      check("t3 ena bit4", 272'(slot_ena[4]), 272'(0));
      do_req("t3 reclaim", 1'b0, 19'h30000, 4'd0);

      // Test 4: bad releases, then a release that leaves a slot enabled.
      do_req("t4 rel0", 1'b1, '0, 4'd0);
      do_req("t4 rel15", 1'b1, '0, 4'd15);
      do_req("t4 rel5", 1'b1, '0, 4'd5);
      do_req("t4 rel5 again", 1'b1, '0, 4'd5);
      do_req("t4 rel1 cnt2", 1'b1, '0, 4'd1);
      check("t4 ena bit0", 272'(slot_ena[0]), 272'(1));

      // Test 5: reset during EVAL drops the request.
      @(negedge clk);
      req_valid   = 1'b1;
      req_release = 1'b0;
      req_addr    = 19'h0abcd;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      check("t5 in reset resp", 272'(resp_valid), 272'(0));
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t5 no resp", 272'(resp_valid), 272'(0));
      end
      check("t5 req_ready", 272'(req_ready), 272'(1));
      check_table("t5");

      // Refcount saturation: 257 allocates, then 254 releases keep the slot and one more frees it.
      for (int k = 0; k < 257; k++) do_req("sat alloc", 1'b0, 19'h05555, 4'd0);
      for (int k = 0; k < 254; k++) do_req("sat rel", 1'b1, '0, 4'd1);
      check("sat still on", 272'(slot_ena[0]), 272'(1));
      do_req("sat last rel", 1'b1, '0, 4'd1);
      check("sat off", 272'(slot_ena[0]), 272'(0));

`ifdef ADDR_SLOT_FLUSH_EN
      // Test 6: flush in IDLE clears the table and wins over a pending request.
      for (int i = 0; i < 3; i++) do_req("t6 fill", 1'b0, 19'(32'h40000 + i), 4'd0);
      @(negedge clk);
      flush       = 1'b1;
      req_valid   = 1'b1;
      req_release = 1'b0;
      req_addr    = 19'h7ffff;
      check("t6 ready low", 272'(req_ready), 272'(0));
      @(negedge clk);
      flush     = 1'b0;
      req_valid = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         m_ena[i] = 1'b0;
         m_cnt[i] = 0;
      end
      check_table("t6");
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t6 no resp", 272'(resp_valid), 272'(0));
      end
      do_req("t6 after", 1'b0, 19'h40001, 4'd0);
`endif

      // Random mix over a small address pool so that hits, full and errors all occur.
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 2) == 0)
            do_req("rnd rel", 1'b1, '0, 4'($urandom_range(0, 15)));
         else
            do_req("rnd alloc", 1'b0, 19'(32'h1000 + $urandom_range(0, 17) * 32'h111), 4'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
